// File: rtl/time_redundancy_pkg.sv
// time_redundancy_pkg: shared state encoding, copy-index width and majority voter for the time-redundancy blocks
package time_redundancy_pkg;
    typedef enum logic {IDLE, SEND} state_t;
    localparam int REP_W = 3;
    // Bitwise 2-of-3 majority; callers zero-extend into and truncate out of the 64-bit carrier.
    function automatic logic [63:0] vote3(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/time_nmr_fsm.sv
// time_nmr_fsm: one replica of the sender's next-state and output logic
// Inputs : voted current state/rep/id/retries/pend/en/has, upstream valid_i/enable_i, downstream ready_i, retry_i
// Outputs: next-state fields (*_d_o), downstream valid_o/rep_o/id_o, upstream ready_o, error_o,
//          load_o (capture data_i), sel_o (drive data_o from the stored element)
module time_nmr_fsm import time_redundancy_pkg::*; #(
    parameter int NUM_REPS    = 3,
    parameter int ID_SIZE     = 1,
    parameter int RW          = 1,
    parameter int MAX_RETRIES = 1
) (
    input  state_t             state_i,
    input  logic [REP_W-1:0]   rep_i,
    input  logic [ID_SIZE-1:0] id_i,
    input  logic [RW-1:0]      retries_i,
    input  logic               pend_i,
    input  logic               en_i,
    input  logic               has_i,
    input  logic               valid_i,
    input  logic               ready_i,
    input  logic               enable_i,
    input  logic               retry_i,
    output state_t             state_d_o,
    output logic [REP_W-1:0]   rep_d_o,
    output logic [ID_SIZE-1:0] id_d_o,
    output logic [RW-1:0]      retries_d_o,
    output logic               pend_d_o,
    output logic               en_d_o,
    output logic               has_d_o,
    output logic               valid_o,
    output logic               ready_o,
    output logic [REP_W-1:0]   rep_o,
    output logic [ID_SIZE-1:0] id_o,
    output logic               error_o,
    output logic               load_o,
    output logic               sel_o
);
    logic last, serve;
    always_comb begin
        state_d_o   = state_i;
        rep_d_o     = rep_i;
        id_d_o      = id_i;
        retries_d_o = retries_i;
        pend_d_o    = pend_i | retry_i;
        en_d_o      = en_i;
        has_d_o     = has_i;
        error_o     = 1'b0;
        load_o      = 1'b0;
        last        = en_i ? (rep_i == REP_W'(NUM_REPS - 1)) : (rep_i == '0);
        serve       = has_i && (retries_i < RW'(MAX_RETRIES));
        valid_o     = state_i == SEND || (valid_i && !pend_i);
        ready_o     = state_i == IDLE && !pend_i;
        rep_o       = state_i == SEND ? rep_i : '0;
        id_o        = state_i == SEND ? id_i : id_i + ID_SIZE'(1);
        sel_o       = state_i == SEND;
        if (state_i == SEND) begin
            if (ready_i) begin
                state_d_o = last ? IDLE : SEND;
                rep_d_o   = last ? '0 : rep_i + REP_W'(1);
            end
        end else if (pend_i) begin
            // A pending replay outranks new input; pulses arriving while it is served fold into it.
            pend_d_o = 1'b0;
            error_o  = has_i && !serve;
            if (serve) begin
                state_d_o   = SEND;
                rep_d_o     = '0;
                retries_d_o = retries_i + RW'(1);
            end
        end else if (valid_i) begin
            load_o      = 1'b1;
            id_d_o      = id_i + ID_SIZE'(1);
            en_d_o      = enable_i;
            retries_d_o = '0;
            has_d_o     = 1'b1;
            // Copy 0 leaves in this very cycle, so a taken beat already counts as sent.
            state_d_o   = (ready_i && !enable_i) ? IDLE : SEND;
            rep_d_o     = (ready_i && enable_i) ? REP_W'(1) : '0;
        end
    end
endmodule

// File: rtl/time_nmr_start.sv
// time_nmr_start: re-issues each accepted element NUM_REPS times with rolling ID and copy index, replay on request
// Ports: clk_i/rst_i (async, active-high); upstream data_i/valid_i/ready_o/enable_i;
//        downstream data_o/id_o/rep_o/valid_o/ready_i; retry_i replay request; error_o retry refused
module time_nmr_start import time_redundancy_pkg::*; #(
    parameter type DataType   = logic,
    parameter int NUM_REPS    = 3,
    parameter int ID_SIZE     = 1,
    parameter int MAX_RETRIES = 1,
    parameter int INTERNAL_TMR = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  DataType            data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output DataType            data_o,
    output logic [ID_SIZE-1:0] id_o,
    output logic [REP_W-1:0]   rep_o,
    output logic               valid_o,
    input  logic               ready_i,
    input  logic               retry_i,
    output logic               error_o
);
    localparam int RW = MAX_RETRIES < 1 ? 1 : $clog2(MAX_RETRIES + 1);
    typedef struct packed {
        state_t             state;
        logic [REP_W-1:0]   rep;
        logic [ID_SIZE-1:0] id;
        logic [RW-1:0]      retries;
        logic               pend;
        logic               en;
        logic               has;
    } regs_t;
    typedef struct packed {
        logic               dvalid;
        logic               uready;
        logic [REP_W-1:0]   drep;
        logic [ID_SIZE-1:0] did;
        logic               error;
        logic               load;
        logic               sel;
    } out_t;
    localparam int SW = $bits(regs_t);
    localparam int OW = $bits(out_t);
    if (NUM_REPS < 2 || NUM_REPS > 7 || SW > 64) begin : g_bad_cfg
        $error("time_nmr_start: NUM_REPS must be 2..7 and ID_SIZE small enough for the voter");
    end
    regs_t   st0_q, st1_q, st2_q, cur;
    regs_t   st_d [3];
    out_t    outs [3];
    out_t    o;
    DataType data_q;
    assign cur = INTERNAL_TMR != 0 ? regs_t'(SW'(vote3(64'(st0_q), 64'(st1_q), 64'(st2_q)))) : st0_q;
    assign o   = INTERNAL_TMR != 0 ? out_t'(OW'(vote3(64'(outs[0]), 64'(outs[1]), 64'(outs[2])))) : outs[0];
    for (genvar r = 0; r < 3; r++) begin : g_rep
        if (r == 0 || INTERNAL_TMR != 0) begin : g_fsm
            time_nmr_fsm #(.NUM_REPS(NUM_REPS), .ID_SIZE(ID_SIZE), .RW(RW), .MAX_RETRIES(MAX_RETRIES)) u_fsm (
                .state_i(cur.state), .rep_i(cur.rep), .id_i(cur.id), .retries_i(cur.retries),
                .pend_i(cur.pend), .en_i(cur.en), .has_i(cur.has),
                .valid_i(valid_i), .ready_i(ready_i), .enable_i(enable_i), .retry_i(retry_i),
                .state_d_o(st_d[r].state), .rep_d_o(st_d[r].rep), .id_d_o(st_d[r].id),
                .retries_d_o(st_d[r].retries), .pend_d_o(st_d[r].pend), .en_d_o(st_d[r].en),
                .has_d_o(st_d[r].has), .valid_o(outs[r].dvalid), .ready_o(outs[r].uready),
                .rep_o(outs[r].drep), .id_o(outs[r].did), .error_o(outs[r].error),
                .load_o(outs[r].load), .sel_o(outs[r].sel)
            );
        end else begin : g_copy
            assign st_d[r] = st_d[0];
            assign outs[r] = outs[0];
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st0_q <= '0;
            st1_q <= '0;
            st2_q <= '0;
        end else begin
            st0_q <= st_d[0];
            st1_q <= st_d[1];
            st2_q <= st_d[2];
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) data_q <= '0;
        else if (o.load) data_q <= data_i;
    end
    // Reset forces every handshake/tag output low even though the idle state would otherwise present id 1.
    assign data_o  = o.sel ? data_q : data_i;
    assign valid_o = o.dvalid & ~rst_i;
    assign ready_o = o.uready & ~rst_i;
    assign error_o = o.error & ~rst_i;
    assign rep_o   = rst_i ? '0 : o.drep;
    assign id_o    = rst_i ? '0 : o.did;
endmodule

// File: tb/tb_time_nmr_start.sv
// tb_time_nmr_start: directed vector table, hand-written corner cases and a randomized scoreboard run
module tb_time_nmr_start;
    localparam int N = 3, IDW = 2, MAXR = 1;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, v = 1'b0, rdy = 1'b0, rt = 1'b0;
    logic [7:0] d = 8'h00, dout;
    logic ro, vo, erro;
    logic [IDW-1:0] ido;
    logic [2:0] repo;
    int errs = 0, checks = 0;
    always #5 clk = ~clk;
    time_nmr_start #(.DataType(logic [7:0]), .NUM_REPS(N), .ID_SIZE(IDW), .MAX_RETRIES(MAXR), .INTERNAL_TMR(1)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .data_i(d), .valid_i(v), .ready_o(ro),
        .data_o(dout), .id_o(ido), .rep_o(repo), .valid_o(vo), .ready_i(rdy), .retry_i(rt), .error_o(erro)
    );
    typedef struct {
        logic v, en, rdy, rt;
        logic [7:0] d;
        logic [15:0] exp;
    } vec_t;
    typedef struct packed {
        logic [7:0] d;
        logic [1:0] id;
        logic [2:0] rep;
    } beat_t;
    beat_t exp_q[$];
    int next_id, used;
    bit has, rt_prev, err_due, last_en;
    logic [7:0] last_d;
    int last_id;
    function automatic vec_t mk(input logic iv, input logic ien, input logic irdy, input logic irt, input logic [7:0] idt,
                                input logic ev, input logic er, input logic [7:0] ed, input logic [1:0] eid,
                                input logic [2:0] erep, input logic eerr);
        vec_t t;
        t.v = iv; t.en = ien; t.rdy = irdy; t.rt = irt; t.d = idt;
        t.exp = {ev, er, ed, eid, erep, eerr};
        return t;
    endfunction
    task automatic row(input vec_t t, input string name);
        @(posedge clk); #1;
        v = t.v; en = t.en; rdy = t.rdy; rt = t.rt; d = t.d;
        @(negedge clk);
        checks++;
        if ({vo, ro, dout, ido, repo, erro} !== t.exp) begin
            errs++;
            $display("FAIL %s got v=%b r=%b d=%h id=%0d rep=%0d err=%b exp v=%b r=%b d=%h id=%0d rep=%0d err=%b",
                     name, vo, ro, dout, ido, repo, erro, t.exp[15], t.exp[14], t.exp[13:6], t.exp[5:4], t.exp[3:1], t.exp[0]);
        end
    endtask
    task automatic chk_rst(input string name);
        checks++;
        if ({vo, ro, repo, ido, erro} !== '0) begin
            errs++;
            $display("FAIL %s got v=%b r=%b rep=%0d id=%0d err=%b exp all zero", name, vo, ro, repo, ido, erro);
        end
    endtask
    task automatic push_elem(input logic [7:0] dd, input int id, input bit e);
        for (int k = 0; k < (e ? N : 1); k++) exp_q.push_back(beat_t'({dd, 2'(id), 3'(k)}));
    endtask
    task automatic cyc(input bit rnd);
        bit busy;
        @(posedge clk); #1;
        rdy = rnd ? ($urandom_range(9) < 7) : 1'b1;
        en = 1'($urandom_range(1));
        d = 8'($urandom);
        v = rnd ? 1'($urandom_range(1)) : 1'b0;
        rt = 1'b0;
        if (rnd && !v && exp_q.size() == 0 && !rt_prev && $urandom_range(5) == 0) rt = 1'b1;
        busy = exp_q.size() != 0 || rt_prev;
        @(negedge clk);
        checks++;
        if (ro !== !busy || erro !== err_due) begin
            errs++;
            $display("FAIL rand_ctrl t=%0t ready=%b exp %b error=%b exp %b", $time, ro, !busy, erro, err_due);
        end
        err_due = 1'b0;
        if (v && ro) begin
            last_d = d; last_id = next_id; last_en = en; has = 1'b1; used = 0;
            push_elem(d, next_id, en);
            next_id = (next_id + 1) % (1 << IDW);
        end
        checks++;
        if (vo !== (exp_q.size() != 0 && !rt_prev)) begin
            errs++;
            $display("FAIL rand_valid t=%0t valid=%b exp %b", $time, vo, exp_q.size() != 0 && !rt_prev);
        end else if (vo && {dout, ido, repo} !== exp_q[0]) begin
            errs++;
            $display("FAIL rand_beat t=%0t got d=%h id=%0d rep=%0d exp d=%h id=%0d rep=%0d",
                     $time, dout, ido, repo, exp_q[0].d, exp_q[0].id, exp_q[0].rep);
        end
        if (vo && rdy && exp_q.size() != 0) void'(exp_q.pop_front());
        if (rt) begin
            if (has && used < MAXR) begin
                used++;
                push_elem(last_d, last_id, last_en);
            end else if (has) err_due = 1'b1;
        end
        rt_prev = rt;
    endtask
    initial begin
        vec_t tbl[$];
        tbl.push_back(mk(1,1,1,0,8'hA5, 1,1,8'hA5,1,0,0));
        tbl.push_back(mk(0,1,1,0,8'h00, 1,0,8'hA5,1,1,0));
        tbl.push_back(mk(0,1,1,0,8'h00, 1,0,8'hA5,1,2,0));
        tbl.push_back(mk(0,1,1,0,8'h00, 0,1,8'h00,2,0,0));
        tbl.push_back(mk(1,0,1,0,8'h10, 1,1,8'h10,2,0,0));
        tbl.push_back(mk(1,0,1,0,8'h11, 1,1,8'h11,3,0,0));
        tbl.push_back(mk(1,0,1,0,8'h12, 1,1,8'h12,0,0,0));
        tbl.push_back(mk(1,0,1,0,8'h13, 1,1,8'h13,1,0,0));
        tbl.push_back(mk(0,0,1,0,8'h00, 0,1,8'h00,2,0,0));
        tbl.push_back(mk(1,1,1,0,8'hC3, 1,1,8'hC3,2,0,0));
        tbl.push_back(mk(0,0,0,0,8'h00, 1,0,8'hC3,2,1,0));
        tbl.push_back(mk(0,1,0,0,8'h00, 1,0,8'hC3,2,1,0));
        tbl.push_back(mk(0,0,0,0,8'h00, 1,0,8'hC3,2,1,0));
        tbl.push_back(mk(0,0,1,0,8'h00, 1,0,8'hC3,2,1,0));
        tbl.push_back(mk(0,1,1,0,8'h00, 1,0,8'hC3,2,2,0));
        tbl.push_back(mk(0,1,1,1,8'h00, 0,1,8'h00,3,0,0));
        tbl.push_back(mk(1,1,1,0,8'h77, 0,0,8'h77,3,0,0));
        tbl.push_back(mk(1,1,1,0,8'h77, 1,0,8'hC3,2,0,0));
        tbl.push_back(mk(0,1,1,0,8'h00, 1,0,8'hC3,2,1,0));
        tbl.push_back(mk(0,1,1,0,8'h00, 1,0,8'hC3,2,2,0));
        tbl.push_back(mk(0,1,1,1,8'h00, 0,1,8'h00,3,0,0));
        tbl.push_back(mk(0,1,1,0,8'h00, 0,0,8'h00,3,0,1));
        tbl.push_back(mk(0,1,1,0,8'h00, 0,1,8'h00,3,0,0));
        tbl.push_back(mk(1,0,0,0,8'h5A, 1,1,8'h5A,3,0,0));
        tbl.push_back(mk(0,1,0,0,8'h00, 1,0,8'h5A,3,0,0));
        tbl.push_back(mk(0,1,1,0,8'h00, 1,0,8'h5A,3,0,0));
        tbl.push_back(mk(0,0,1,0,8'h00, 0,1,8'h00,0,0,0));
        v = 1'b1; en = 1'b1; rdy = 1'b1; d = 8'h5A;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_rst("reset_hold");
        @(posedge clk); #1 rst = 1'b0; v = 1'b0;
        foreach (tbl[i]) row(tbl[i], $sformatf("vec%0d", i));
        row(mk(1,1,1,0,8'hE1, 1,1,8'hE1,0,0,0), "tmr_c0");
        force dut.st1_q = ~dut.st0_q;
        row(mk(0,0,1,0,8'h00, 1,0,8'hE1,0,1,0), "tmr_c1");
        row(mk(0,0,1,0,8'h00, 1,0,8'hE1,0,2,0), "tmr_c2");
        row(mk(0,0,1,0,8'h00, 0,1,8'h00,1,0,0), "tmr_idle");
        release dut.st1_q;
        row(mk(1,1,0,0,8'hE2, 1,1,8'hE2,1,0,0), "tmr2_c0");
        force dut.st0_q = ~dut.st2_q;
        row(mk(0,1,1,0,8'h00, 1,0,8'hE2,1,0,0), "tmr2_c0b");
        row(mk(0,1,1,0,8'h00, 1,0,8'hE2,1,1,0), "tmr2_c1");
        release dut.st0_q;
        row(mk(0,1,1,0,8'h00, 1,0,8'hE2,1,2,0), "tmr2_c2");
        row(mk(0,1,1,0,8'h00, 0,1,8'h00,2,0,0), "tmr2_idle");
        row(mk(1,1,1,0,8'h3C, 1,1,8'h3C,2,0,0), "rst_mid_c0");
        @(posedge clk); #3 rst = 1'b1; v = 1'b0;
        @(negedge clk);
        chk_rst("rst_async");
        @(posedge clk); #1 rst = 1'b0;
        row(mk(0,1,1,1,8'h00, 0,1,8'h00,1,0,0), "retry_after_rst");
        row(mk(0,1,1,0,8'h00, 0,0,8'h00,1,0,0), "retry_no_elem");
        row(mk(0,1,1,0,8'h00, 0,1,8'h00,1,0,0), "idle_after_rst");
        row(mk(1,1,1,0,8'h99, 1,1,8'h99,1,0,0), "id_restart_c0");
        row(mk(0,1,1,0,8'h00, 1,0,8'h99,1,1,0), "id_restart_c1");
        row(mk(0,1,1,0,8'h00, 1,0,8'h99,1,2,0), "id_restart_c2");
        row(mk(0,1,1,0,8'h00, 0,1,8'h00,2,0,0), "id_restart_idle");
        @(posedge clk); #1 rst = 1'b1; v = 1'b0; rt = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        next_id = 1; has = 1'b0; used = 0; rt_prev = 1'b0; err_due = 1'b0; exp_q.delete();
        for (int c = 0; c < 3000; c++) cyc(1'b1);
        for (int c = 0; c < 60 && (exp_q.size() != 0 || rt_prev || err_due); c++) cyc(1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL drain left=%0d beats exp 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
